// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and the default word-address width.
package lsu_pkg;

    localparam int LSU_WORD_AW_DEF = 10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // A request is rejected when its size is reserved or its address is not naturally aligned.
    function automatic logic lsu_access_err(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges sub-word store data into the old word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        load_data   = rd_word;
        merged_word = rd_word;
        lane8       = rd_word[{addr_lo, 3'b000} +: 8];
        lane16      = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SZ_BYTE: begin
                load_data = {{24{lane8[7] & ~is_unsigned}}, lane8};
                merged_word[{addr_lo, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{lane16[15] & ~is_unsigned}}, lane16};
                if (addr_lo[1]) begin
                    merged_word[31:16] = new_data[15:0];
                end else begin
                    merged_word[15:0] = new_data[15:0];
                end
            end
            default: begin
                load_data   = rd_word;
                merged_word = new_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit driving a single-port word memory with registered reads.
// Optional LSU_PERF_CNT_EN adds load_count/store_count completion counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_AW = LSU_WORD_AW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WORD_AW+1:0] req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [31:0]        mem_write_data,
    output logic               mem_memwrite,
    output logic               mem_memread,
    input  logic [31:0]        mem_read_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]        load_count,
    output logic [31:0]        store_count
`endif
);

    lsu_state_e         state_q, state_d;
    logic               write_q, write_d;
    lsu_size_e          size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic [WORD_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        load_data, merged_word;
    lsu_size_e          req_size_e;
    logic               req_err;
`ifdef LSU_PERF_CNT_EN
    logic [31:0]        load_count_q, load_count_d;
    logic [31:0]        store_count_q, store_count_d;
`endif

    assign req_size_e = lsu_size_e'(req_size);
    assign req_err    = lsu_access_err(req_size_e, req_addr[1:0]);

    // mem_wdata_q carries the raw store data until MERGE overwrites it with the merged word.
    lsu_lane_align u_lane_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .addr_lo     (addr_lo_q),
        .rd_word     (mem_read_data),
        .new_data    (mem_wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_lo_d    = addr_lo_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
`ifdef LSU_PERF_CNT_EN
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d      = req_write;
                    size_d       = req_size_e;
                    unsigned_d   = req_unsigned;
                    addr_lo_d    = req_addr[1:0];
                    mem_addr_d   = req_addr[WORD_AW+1:2];
                    mem_wdata_d  = req_wdata;
                    resp_err_d   = req_err;
                    resp_rdata_d = 32'd0;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_write && req_size_e == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: state_d = ST_MERGE;
            ST_MERGE: begin
                if (write_q) begin
                    mem_wdata_d = merged_word;
                    state_d     = ST_WRITE;
                end else begin
                    resp_rdata_d = load_data;
                    state_d      = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef LSU_PERF_CNT_EN
                if (!resp_err_q) begin
                    if (write_q) begin
                        store_count_d = store_count_q + 32'd1;
                    end else begin
                        load_count_d = load_count_q + 32'd1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            unsigned_q   <= 1'b0;
            addr_lo_q    <= 2'b00;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
`ifdef LSU_PERF_CNT_EN
            load_count_q  <= 32'd0;
            store_count_q <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_lo_q    <= addr_lo_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef LSU_PERF_CNT_EN
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
`endif
        end
    end

    // Strobes are gated by reset so an abort in READ/WRITE never reaches the memory.
    assign req_ready      = (state_q == ST_IDLE) && !reset;
    assign resp_valid     = (state_q == ST_RESP) && !reset;
    assign mem_memread    = (state_q == ST_READ) && !reset;
    assign mem_memwrite   = (state_q == ST_WRITE) && !reset;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
`ifdef LSU_PERF_CNT_EN
    assign load_count  = load_count_q;
    assign store_count = store_count_q;
`endif

endmodule
